// File: rtl/qif_pkg.sv
// Shared types and saturation helper for the QIF neuron and its synapse front end.
package qif_pkg;

  localparam int I_W   = 8;
  localparam int SUM_W = 11;

  typedef logic signed [I_W-1:0]   current_t;
  typedef logic signed [SUM_W-1:0] sum_t;

  localparam current_t I_MAX = 8'sd127;
  localparam current_t I_MIN = -8'sd128;

  typedef struct packed {
    current_t val;
    logic     sat;
  } sat_res_t;

  // Clamp a wide intermediate current into the 8-bit range, flagging any clip.
  function automatic sat_res_t sat8(input sum_t x);
    sat_res_t r;
    if (x > sum_t'(I_MAX)) begin
      r.val = I_MAX;
      r.sat = 1'b1;
    end else if (x < sum_t'(I_MIN)) begin
      r.val = I_MIN;
      r.sat = 1'b1;
    end else begin
      r.val = x[I_W-1:0];
      r.sat = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/qif_synapse_if.sv
// Spike, weight-write and current-output bundle between a driver and qif_synapse.
interface qif_synapse_if #(
  parameter int N_IN = 4
);
  import qif_pkg::*;

  localparam int AW = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic            enable;
  logic [N_IN-1:0] spike_in;
  logic            w_we;
  logic [AW-1:0]   w_addr;
  current_t        w_data;
  current_t        I_syn;
  logic            sat;

  modport master (
    output enable, spike_in, w_we, w_addr, w_data,
    input  I_syn, sat
  );

  modport slave (
    input  enable, spike_in, w_we, w_addr, w_data,
    output I_syn, sat
  );

endinterface

// File: rtl/qif_weight_sum.sv
// Combinational masked adder: sums the weights of all inputs that spiked this cycle.
module qif_weight_sum
  import qif_pkg::*;
#(
  parameter int N_IN = 4
) (
  input  current_t [N_IN-1:0] weights_i,
  input  logic     [N_IN-1:0] spike_i,
  output sum_t                sum_o
);

  always_comb begin
    sum_o = '0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (spike_i[k]) begin
        sum_o = sum_o + sum_t'($signed(weights_i[k]));
      end
    end
  end

endmodule

// File: rtl/qif_synapse.sv
// Synaptic current generator: weighted spike integration with periodic exponential decay,
// saturated to an 8-bit signed current.
module qif_synapse
  import qif_pkg::*;
#(
  parameter int N_IN         = 4,
  parameter int DECAY_SHIFT  = 3,
  parameter int DECAY_PERIOD = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  qif_synapse_if.slave  bus
);

  localparam int         AW       = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [7:0] CNT_LAST = 8'(DECAY_PERIOD - 1);

  current_t [N_IN-1:0] w_q;
  logic [7:0]          cnt_q, cnt_d;
  current_t            i_q;
  logic                sat_q;

  sum_t     sum;
  logic     tick;
  current_t shr;
  current_t dec;
  sum_t     nxt;
  sat_res_t clamp;

  qif_weight_sum #(.N_IN(N_IN)) u_sum (
    .weights_i (w_q),
    .spike_i   (bus.spike_in),
    .sum_o     (sum)
  );

  always_comb begin
    tick  = bus.enable && (cnt_q == CNT_LAST);
    cnt_d = cnt_q;
    if (bus.enable) begin
      cnt_d = tick ? '0 : cnt_q + 8'd1;
    end

    // A small positive current would shift to zero and stall; force a unit step instead.
    shr = i_q >>> DECAY_SHIFT;
    dec = '0;
    if (tick) begin
      dec = (shr == '0 && i_q > 0) ? current_t'(1) : shr;
    end

    nxt   = sum_t'(i_q) - sum_t'(dec) + sum;
    clamp = sat8(nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q   <= '0;
      cnt_q <= '0;
      i_q   <= '0;
      sat_q <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < N_IN; k++) begin
        if (bus.w_we && bus.w_addr == AW'(k)) begin
          w_q[k] <= bus.w_data;
        end
      end
      cnt_q <= cnt_d;
      if (bus.enable) begin
        i_q   <= clamp.val;
        sat_q <= clamp.sat;
      end else begin
        sat_q <= 1'b0;
      end
    end
  end

  assign bus.I_syn = i_q;
  assign bus.sat   = sat_q;

endmodule

// File: tb/tb_qif_synapse.sv
// Directed scoreboard bench for qif_synapse (N_IN=4, DECAY_SHIFT=3, DECAY_PERIOD=4).
module tb_qif_synapse;
  import qif_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   edge_n = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int    cyc;
    int    ival;
    logic  sval;
    string nm;
  } exp_t;

  exp_t sb[$];

  qif_synapse_if #(.N_IN(4)) sif ();

  qif_synapse #(
    .N_IN         (4),
    .DECAY_SHIFT  (3),
    .DECAY_PERIOD (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic compare(input string nm, input int got_i, input logic got_s,
                         input int exp_i, input logic exp_s);
    checks++;
    if (got_i != exp_i || got_s !== exp_s) begin
      errors++;
      $display("FAIL %s @edge %0d: I_syn=%0d sat=%0b, expected I_syn=%0d sat=%0b",
               nm, edge_n, got_i, got_s, exp_i, exp_s);
    end
  endtask

  // Monitor: pops every expectation due at this edge, sampled 1 time unit after it.
  always @(posedge clk) begin
    exp_t e;
    #1;
    while (sb.size() != 0 && sb[0].cyc <= edge_n) begin
      e = sb.pop_front();
      if (e.cyc < edge_n) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for edge %0d missed (now %0d)", e.nm, e.cyc, edge_n);
      end else begin
        compare(e.nm, int'(sif.I_syn), sif.sat, e.ival, e.sval);
      end
    end
  end

  task automatic step(input logic en, input logic [3:0] spk, input logic we,
                      input logic [1:0] addr, input int data,
                      input int exp_i, input logic exp_s, input string nm);
    exp_t e;
    @(negedge clk);
    sif.enable   = en;
    sif.spike_in = spk;
    sif.w_we     = we;
    sif.w_addr   = addr;
    sif.w_data   = current_t'(data);
    e.cyc  = edge_n + 1;
    e.ival = exp_i;
    e.sval = exp_s;
    e.nm   = nm;
    sb.push_back(e);
  endtask

  task automatic idle(input int exp_i, input logic exp_s, input string nm);
    step(1'b1, 4'b0000, 1'b0, 2'd0, 0, exp_i, exp_s, nm);
  endtask

  task automatic wr(input logic [1:0] addr, input int data, input int exp_i, input string nm);
    step(1'b1, 4'b0000, 1'b1, addr, data, exp_i, 1'b0, nm);
  endtask

  task automatic sp(input logic [3:0] spk, input int exp_i, input logic exp_s, input string nm);
    step(1'b1, spk, 1'b0, 2'd0, 0, exp_i, exp_s, nm);
  endtask

  task automatic clear_inputs();
    sif.enable   = 1'b0;
    sif.spike_in = '0;
    sif.w_we     = 1'b0;
    sif.w_addr   = '0;
    sif.w_data   = '0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compare("por_reset", int'(sif.I_syn), sif.sat, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after release; decay phase ends back at counter 0.
    for (int i = 0; i < 20; i++) idle(0, 1'b0, "idle_zero");

    // Weighted sum and one-cycle latency, then decay at the tick.
    wr(2'd0, 20, 0, "wr_w0");
    wr(2'd1, -5, 0, "wr_w1");
    sp(4'b0011, 15, 1'b0, "sum_w0_w1");
    idle(14, 1'b0, "tick_15");

    // Positive saturation.
    wr(2'd2, -14, 14, "wr_w2");
    sp(4'b0100, 0, 1'b0, "cancel_to_0");
    wr(2'd0, 100, 0, "wr_w0_100");
    sp(4'b0001, 100, 1'b0, "pos_first");
    sp(4'b0001, 127, 1'b1, "pos_sat");
    wr(2'd2, -127, 127, "sat_clears");
    sp(4'b0100, 0, 1'b0, "cancel_127");

    // Negative saturation, then decay of -128.
    wr(2'd0, -100, 0, "wr_w0_m100");
    sp(4'b0001, -100, 1'b0, "neg_first");
    sp(4'b0001, -128, 1'b1, "neg_sat");
    idle(-128, 1'b0, "neg_hold");
    idle(-112, 1'b0, "tick_m128");

    // Decay of -16.
    wr(2'd3, 96, -112, "wr_w3_96");
    sp(4'b1000, -16, 1'b0, "to_m16");
    idle(-16, 1'b0, "hold_m16");
    idle(-14, 1'b0, "tick_m16");

    // Small positive current forced down by one per tick.
    wr(2'd3, 17, -14, "wr_w3_17");
    sp(4'b1000, 3, 1'b0, "to_3");
    idle(3, 1'b0, "hold_3");
    idle(2, 1'b0, "tick_3");
    for (int i = 0; i < 3; i++) idle(2, 1'b0, "hold_2");
    idle(1, 1'b0, "tick_2");
    for (int i = 0; i < 3; i++) idle(1, 1'b0, "hold_1");
    idle(0, 1'b0, "tick_1");

    // -1 decays to 0; zero stays zero across a tick.
    wr(2'd3, -1, 0, "wr_w3_m1");
    sp(4'b1000, -1, 1'b0, "to_m1");
    idle(-1, 1'b0, "hold_m1");
    idle(0, 1'b0, "tick_m1");
    for (int i = 0; i < 4; i++) idle(0, 1'b0, "zero_stays");

    // Write/spike collision on index 0.
    wr(2'd0, 10, 0, "wr_w0_10");
    step(1'b1, 4'b0001, 1'b1, 2'd0, 50, 10, 1'b0, "collide_old_w");
    sp(4'b0001, 60, 1'b0, "new_w_applies");
    idle(53, 1'b0, "tick_60");

    // Enable gating: state and decay phase freeze, writes still land.
    idle(53, 1'b0, "pre_gate0");
    idle(53, 1'b0, "pre_gate1");
    for (int i = 0; i < 10; i++)
      step(1'b0, 4'b1111, (i == 4), 2'd3, -7, 53, 1'b0, "gated_hold");
    idle(53, 1'b0, "resume_no_tick");
    idle(47, 1'b0, "resume_tick");
    sp(4'b1000, 40, 1'b0, "gated_write");

    // Asynchronous reset mid-run clears current, weights and phase.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    clear_inputs();
    #1;
    compare("async_reset", int'(sif.I_syn), sif.sat, 0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) sp(4'b1111, 0, 1'b0, "weights_cleared");
    wr(2'd0, 16, 0, "wr_w0_16");
    sp(4'b0001, 16, 1'b0, "to_16");
    idle(16, 1'b0, "hold_16");
    idle(14, 1'b0, "first_tick_after_rst");

    // Let the monitor drain; anything left over was never presented.
    repeat (3) @(posedge clk);
    #2;
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation for edge %0d never checked", e.nm, e.cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
